rr_arbiter_8: RTL

Eight-requester round-robin arbiter. It shares one resource among eight clients and drives the resource's 3-bit select together with the matching one-hot grant, decoded internally as a 3-to-8 decode of the grant index. A grant is held for as long as the owner keeps its request high. Priority then rotates so that no requester starves. The block sits between client request lines and any 8-way shared datapath (mux select, bus enable, memory port).

---
 rtl/rr_arbiter_8.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-requester round-robin arbiter with registered one-hot
// grant, binary grant index and valid flag. A grant is held while its owner
// keeps requesting; priority rotates to the requester after the last owner.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to add a hold counter that
// revokes an owner after HOLD_MAX cycles when another requester is waiting.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner, all outputs zero, waiting for any request
// OWNED | grant_idx owns the resource, grant/grant_valid asserted
module rr_arbiter_8 #(
    parameter int SIZE_SEL = 3,
    parameter int SIZE_REQ = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE_REQ-1:0] req,
    output logic [SIZE_REQ-1:0] grant,
    output logic [SIZE_SEL-1:0] grant_idx,
    output logic                grant_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state;
    logic [SIZE_SEL-1:0] ptr;
    logic [SIZE_REQ-1:0] cand;
    logic [SIZE_SEL-1:0] pick;
    logic                any_other;
    logic                owner_req;
    logic                handover;

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0]          hold_cnt;
    logic                revoke;
`endif

    // Elaboration-time guard on the parameter set this block supports.
    if (SIZE_SEL != 3 || SIZE_REQ != (1 << SIZE_SEL) || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_param_err
        $error("rr_arbiter_8: unsupported parameter combination");
    end

    // Candidate requests: the current owner is excluded so a handover never re-picks it.
    always_comb begin
        cand = req;
        if (state == OWNED) begin
            cand[grant_idx] = 1'b0;
        end
        any_other = |cand;
        owner_req = req[grant_idx];
    end

    // Round-robin scan of the candidates starting at ptr, wrapping 7 -> 0.
    always_comb begin
        logic                found;
        logic [SIZE_SEL-1:0] pos;
        pick  = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < SIZE_REQ; k++) begin
            pos = ptr + SIZE_SEL'(k);
            if (!found && cand[pos]) begin
                pick  = pos;
                found = 1'b1;
            end
        end
    end

    // Owner gives up the resource: voluntary release or (optionally) timeout revoke.
    always_comb begin
`ifdef RR_ARB_TIMEOUT_EN
        revoke   = owner_req && (hold_cnt == 8'(HOLD_MAX)) && any_other;
        handover = !owner_req || revoke;
`else
        handover = !owner_req;
`endif
    end

    // Arbiter FSM with registered outputs; a new grant also advances ptr past the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_other) begin
                        state       <= OWNED;
                        grant       <= SIZE_REQ'(1) << pick;
                        grant_idx   <= pick;
                        grant_valid <= 1'b1;
                        ptr         <= pick + SIZE_SEL'(1);
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt    <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (handover) begin
                        if (any_other) begin
                            grant       <= SIZE_REQ'(1) << pick;
                            grant_idx   <= pick;
                            grant_valid <= 1'b1;
                            ptr         <= pick + SIZE_SEL'(1);
`ifdef RR_ARB_TIMEOUT_EN
                            hold_cnt    <= '0;
`endif
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_idx   <= '0;
                            grant_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
                            hold_cnt    <= '0;
`endif
                        end
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        if (hold_cnt != 8'(HOLD_MAX)) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_idx   <= '0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
